// File: rtl/tlc_phase_scheduler.sv
// Highway/country/pedestrian phase scheduler driven by one saturating elapsed-cycle counter.
// Lamp outputs are a Moore decode of the state register; ped_ack is registered on PW entry.
module tlc_phase_scheduler #(
   parameter int unsigned MIN_GREEN   = 8,
   parameter int unsigned Y2R_CYCLES  = 3,
   parameter int unsigned R2G_CYCLES  = 2,
   parameter int unsigned CG_MIN      = 4,
   parameter int unsigned CG_MAX      = 16,
   parameter int unsigned WALK_CYCLES = 6
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       car_x,
   input  logic       ped_req,
   output logic [1:0] hwy,
   output logic [1:0] cntry,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      S_HG = 3'd0,
      S_HY = 3'd1,
      S_AR = 3'd2,
      S_CG = 3'd3,
      S_CY = 3'd4,
      S_PW = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      T_HWY   = 2'd0,
      T_CNTRY = 2'd1,
      T_PED   = 2'd2
   } tgt_t;

   localparam logic [1:0] LAMP_RED = 2'd0;
   localparam logic [1:0] LAMP_YEL = 2'd1;
   localparam logic [1:0] LAMP_GRN = 2'd2;

   // Counter values on the last cycle of each timed interval.
   localparam logic [7:0] L_MG_LAST   = 8'(MIN_GREEN - 1);
   localparam logic [7:0] L_Y2R_LAST  = 8'(Y2R_CYCLES - 1);
   localparam logic [7:0] L_R2G_LAST  = 8'(R2G_CYCLES - 1);
   localparam logic [7:0] L_CGMN_LAST = 8'(CG_MIN - 1);
   localparam logic [7:0] L_CGMX_LAST = 8'(CG_MAX - 1);
   localparam logic [7:0] L_WALK_LAST = 8'(WALK_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   tgt_t       r_tgt;
   tgt_t       w_tgt_nxt;
   logic [7:0] r_cnt;
   logic       r_ped_pend;
   logic       w_ped_pend_nxt;
   logic       r_ped_ack;
   logic       w_enter_pw;

   always_comb begin
      w_state_nxt = r_state;
      w_tgt_nxt   = r_tgt;
      case (r_state)
         S_HG: begin
            // Country wins over a pending pedestrian; a ped_req in this same cycle is not yet visible.
            if ((r_cnt >= L_MG_LAST) && (car_x || r_ped_pend)) begin
               w_state_nxt = S_HY;
               w_tgt_nxt   = car_x ? T_CNTRY : T_PED;
            end
         end
         S_HY: begin
            if (r_cnt == L_Y2R_LAST) w_state_nxt = S_AR;
         end
         S_AR: begin
            if (r_cnt == L_R2G_LAST) begin
               case (r_tgt)
                  T_CNTRY: w_state_nxt = S_CG;
                  T_PED:   w_state_nxt = S_PW;
                  default: w_state_nxt = S_HG;
               endcase
            end
         end
         S_CG: begin
            if ((r_cnt >= L_CGMN_LAST) && (!car_x || (r_cnt == L_CGMX_LAST)))
               w_state_nxt = S_CY;
         end
         S_CY: begin
            if (r_cnt == L_Y2R_LAST) begin
               w_state_nxt = S_AR;
               w_tgt_nxt   = r_ped_pend ? T_PED : T_HWY;
            end
         end
         S_PW: begin
            if (r_cnt == L_WALK_LAST) begin
               w_state_nxt = S_AR;
               w_tgt_nxt   = T_HWY;
            end
         end
         default: begin
            w_state_nxt = S_HG;
            w_tgt_nxt   = T_HWY;
         end
      endcase
   end

   assign w_enter_pw = (w_state_nxt == S_PW) && (r_state != S_PW);

   always_comb begin
      w_ped_pend_nxt = r_ped_pend;
      if (w_enter_pw)
         w_ped_pend_nxt = 1'b0;
      else if (ped_req && (r_state != S_PW))
         w_ped_pend_nxt = 1'b1;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state    <= S_HG;
         r_tgt      <= T_HWY;
         r_cnt      <= 8'd0;
         r_ped_pend <= 1'b0;
         r_ped_ack  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_tgt      <= w_tgt_nxt;
         r_ped_pend <= w_ped_pend_nxt;
         r_ped_ack  <= w_enter_pw;
         if (w_state_nxt != r_state)
            r_cnt <= 8'd0;
         else if (r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   always_comb begin
      hwy   = LAMP_RED;
      cntry = LAMP_RED;
      walk  = 1'b0;
      case (r_state)
         S_HG:    hwy   = LAMP_GRN;
         S_HY:    hwy   = LAMP_YEL;
         S_CG:    cntry = LAMP_GRN;
         S_CY:    cntry = LAMP_YEL;
         S_PW:    walk  = 1'b1;
         default: ;
      endcase
   end

   assign ped_ack = r_ped_ack;
   assign phase   = r_state;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler: per-cycle phase/lamp checks against hand-derived sequences.
module tb_tlc_phase_scheduler;

   localparam int HG = 0;
   localparam int HY = 1;
   localparam int AR = 2;
   localparam int CG = 3;
   localparam int CY = 4;
   localparam int PW = 5;

   logic       clock   = 1'b0;
   logic       clear   = 1'b0;
   logic       car_x   = 1'b0;
   logic       ped_req = 1'b0;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic       walk;
   logic       ped_ack;
   logic [2:0] phase;

   int n_chk  = 0;
   int n_fail = 0;

   tlc_phase_scheduler dut (
      .clock   (clock),
      .clear   (clear),
      .car_x   (car_x),
      .ped_req (ped_req),
      .hwy     (hwy),
      .cntry   (cntry),
      .walk    (walk),
      .ped_ack (ped_ack),
      .phase   (phase)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_hwy(input int ph);
      return (ph == HG) ? 2 : ((ph == HY) ? 1 : 0);
   endfunction

   function automatic int exp_cntry(input int ph);
      return (ph == CG) ? 2 : ((ph == CY) ? 1 : 0);
   endfunction

   // Checks n consecutive cycles of one phase; ped_ack expected only at cycle index ack_at.
   task automatic run_seg(input string tag, input int ph, input int n, input int ack_at);
      for (int i = 0; i < n; i++) begin
         check({tag, ".phase"},   32'(phase),   ph);
         check({tag, ".hwy"},     32'(hwy),     exp_hwy(ph));
         check({tag, ".cntry"},   32'(cntry),   exp_cntry(ph));
         check({tag, ".walk"},    32'(walk),    (ph == PW) ? 1 : 0);
         check({tag, ".ped_ack"}, 32'(ped_ack), (i == ack_at) ? 1 : 0);
         @(negedge clock);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".phase"},   32'(phase),   0);
      check({tag, ".hwy"},     32'(hwy),     2);
      check({tag, ".cntry"},   32'(cntry),   0);
      check({tag, ".walk"},    32'(walk),    0);
      check({tag, ".ped_ack"}, 32'(ped_ack), 0);
   endtask

   // Leaves the bench at a negedge with clear just released: that cycle is HG cycle 0.
   task automatic apply_reset(input string tag);
      clear   = 1'b0;
      car_x   = 1'b0;
      ped_req = 1'b0;
      @(negedge clock);
      check_reset_vals(tag);
      @(negedge clock);
      clear = 1'b1;
   endtask

   always @(negedge clock) begin
      if (clear) begin
         check("safety.both_nonred", 32'(hwy != 2'd0 && cntry != 2'd0), 0);
         check("safety.walk_nonred", 32'(walk && (hwy != 2'd0 || cntry != 2'd0)), 0);
      end
   end

   initial begin
      // Idle: highway green forever.
      apply_reset("rst1");
      run_seg("idle.hg", HG, 200, -1);

      // Country request, car leaves after six cycles of country green.
      apply_reset("rst2");
      car_x = 1'b1;
      run_seg("cx.hg", HG, 8, -1);
      run_seg("cx.hy", HY, 3, -1);
      run_seg("cx.ar", AR, 2, -1);
      run_seg("cx.cg", CG, 5, -1);
      car_x = 1'b0;
      run_seg("cx.cg_last", CG, 1, -1);
      run_seg("cx.cy", CY, 3, -1);
      run_seg("cx.ar2", AR, 2, -1);
      run_seg("cx.hg2", HG, 4, -1);

      // Permanent country demand: country green capped, 34-cycle period.
      apply_reset("rst3");
      car_x = 1'b1;
      for (int r = 0; r < 2; r++) begin
         run_seg("max.hg", HG, 8, -1);
         run_seg("max.hy", HY, 3, -1);
         run_seg("max.ar", AR, 2, -1);
         run_seg("max.cg", CG, 16, -1);
         run_seg("max.cy", CY, 3, -1);
         run_seg("max.ar2", AR, 2, -1);
      end
      run_seg("max.hg3", HG, 1, -1);
      car_x = 1'b0;

      // Single-cycle pedestrian pulse at HG cycle 2.
      apply_reset("rst4");
      run_seg("ped.hg_a", HG, 2, -1);
      ped_req = 1'b1;
      run_seg("ped.hg_b", HG, 1, -1);
      ped_req = 1'b0;
      run_seg("ped.hg_c", HG, 5, -1);
      run_seg("ped.hy", HY, 3, -1);
      run_seg("ped.ar", AR, 2, -1);
      run_seg("ped.pw", PW, 6, 0);
      run_seg("ped.ar2", AR, 2, -1);
      run_seg("ped.hg2", HG, 20, -1);

      // Car and pedestrian together; car drop during HY keeps the granted country phase.
      apply_reset("rst5");
      car_x   = 1'b1;
      ped_req = 1'b1;
      run_seg("both.hg_a", HG, 1, -1);
      ped_req = 1'b0;
      run_seg("both.hg_b", HG, 7, -1);
      car_x = 1'b0;
      run_seg("both.hy", HY, 3, -1);
      run_seg("both.ar", AR, 2, -1);
      run_seg("both.cg", CG, 4, -1);
      run_seg("both.cy", CY, 3, -1);
      run_seg("both.ar2", AR, 2, -1);
      run_seg("both.pw_a", PW, 2, 0);
      ped_req = 1'b1;
      run_seg("both.pw_b", PW, 1, -1);
      ped_req = 1'b0;
      run_seg("both.pw_c", PW, 3, -1);
      run_seg("both.ar3", AR, 2, -1);
      run_seg("both.hg2", HG, 20, -1);

      // Asynchronous reset in the middle of CY with a pedestrian still pending.
      apply_reset("rst6");
      car_x   = 1'b1;
      ped_req = 1'b1;
      run_seg("mid.hg_a", HG, 1, -1);
      ped_req = 1'b0;
      run_seg("mid.hg_b", HG, 7, -1);
      car_x = 1'b0;
      run_seg("mid.hy", HY, 3, -1);
      run_seg("mid.ar", AR, 2, -1);
      run_seg("mid.cg", CG, 4, -1);
      run_seg("mid.cy", CY, 1, -1);
      #2 clear = 1'b0;
      #1 check_reset_vals("mid.async");
      @(negedge clock);
      check_reset_vals("mid.held");
      clear = 1'b1;
      car_x = 1'b1;
      run_seg("post.hg", HG, 8, -1);
      car_x = 1'b0;
      run_seg("post.hy", HY, 3, -1);
      run_seg("post.ar", AR, 2, -1);
      run_seg("post.cg", CG, 4, -1);
      run_seg("post.cy", CY, 3, -1);
      run_seg("post.ar2", AR, 2, -1);
      run_seg("post.hg2", HG, 20, -1);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/tlc_phase_scheduler.md
Name: tlc_phase_scheduler

Overview:
- Cycle-counted phase scheduler for a highway/country intersection with a pedestrian crossing.
- Arbitrates between three requesters, which share one all-red clearance interval:
  - highway: the default owner;
  - country: vehicle sensor car_x;
  - pedestrian: latched ped_req.
- All yellow and red delays use a synchronous elapsed-cycle counter, with no event waits inside combinational logic.
- Drives the hwy/cntry lamp codes directly and adds walk/ped_ack for the crossing.

Parameters:
- MIN_GREEN, 8: minimum highway-green cycles before any request is honoured.
- Y2R_CYCLES, 3: yellow duration in cycles, for both roads.
- R2G_CYCLES, 2: all-red clearance duration in cycles.
- CG_MIN, 4: minimum country-green cycles.
- CG_MAX, 16: maximum country-green cycles; country green ends here even if car_x is still high.
- WALK_CYCLES, 6: pedestrian walk duration in cycles.
- Legal values: every parameter is in 1..255, and CG_MAX >= CG_MIN.

Ports:
- clock, input, 1: sole clock; all state changes on the rising edge.
- clear, input, 1: asynchronous, active-low reset.
- car_x, input, 1: country-road vehicle present; level, synchronous to clock.
- ped_req, input, 1: pedestrian button; any high sample is a request.
- hwy, output, 2: highway lamp code, RED=0, YELLOW=1, GREEN=2.
- cntry, output, 2: country lamp code, same encoding as hwy.
- walk, output, 1: pedestrian walk lamp.
- ped_ack, output, 1: one-cycle pulse on the first cycle of walk.
- phase, output, 3: current state encoding, for debug and observation.

Behaviour:
- State encoding: HG=0, HY=1, AR=2, CG=3, CY=4, PW=5. Codes 6 and 7 are illegal and go to HG on the next edge.
- Elapsed counter cnt:
  - 8 bits; cleared to 0 on every state change;
  - otherwise increments, saturating at 255.
- "Dur elapsed" means cnt == D-1. A state whose exit condition is only elapsed time lasts exactly D cycles.
- Target register tgt ∈ {HWY, CNTRY, PED} selects the state that AR exits to.
- ped_pend:
  - set on any cycle where ped_req=1 and state != PW;
  - cleared on the edge that enters PW; clear wins over set on that edge;
  - ped_req while in PW is ignored.
- Transitions:
  - HG → HY when cnt >= MIN_GREEN-1 and (car_x or ped_pend). Sets tgt = CNTRY if car_x, else PED; country has priority.
  - HY → AR when Y2R_CYCLES has elapsed.
  - AR → HG, CG or PW according to tgt, when R2G_CYCLES has elapsed.
  - CG → CY when cnt >= CG_MIN-1 and (!car_x or cnt == CG_MAX-1).
  - CY → AR when Y2R_CYCLES has elapsed. Sets tgt = PED if ped_pend, else HWY.
  - PW → AR when WALK_CYCLES has elapsed. Sets tgt = HWY.
  - Result: no pedestrian request waits more than one country phase.
- Outputs are a Moore decode of the state register:
  - HG: hwy=GREEN, cntry=RED.
  - HY: hwy=YELLOW, cntry=RED.
  - AR: both RED.
  - CG: hwy=RED, cntry=GREEN.
  - CY: hwy=RED, cntry=YELLOW.
  - PW: both RED, walk=1.
  - Any other state: both RED, walk=0.
  - ped_ack is registered and is high only on the first PW cycle.
- Safety invariant: hwy and cntry are never both non-RED; walk=1 only while both are RED.
- Reset values, taking effect immediately when clear falls, without waiting for a clock edge:
  - state=HG, cnt=0, tgt=HWY, ped_pend=0;
  - hwy=GREEN, cntry=RED, walk=0, ped_ack=0, phase=0.
- Reset mid-operation discards any pending request and tgt.
- Release of clear is sampled on a clock edge. The first count cycle is the first rising edge with clear=1.
- car_x is sampled only at the decision points listed above. A car_x drop during HY/AR does not abort a country phase that is already granted.
- Simultaneous ped_req and the HG exit decision: the request is latched that cycle but does not affect the tgt chosen that cycle unless ped_pend was already set.

Test Plan:
- Hold clear low, then release, with no requests → hwy=GREEN, cntry=RED and phase=0 for 200 cycles; walk and ped_ack stay 0.
- Hold car_x=1 from reset release, then drop car_x at CG cycle 6 →
  - HG lasts 8 cycles, HY 3, AR 2;
  - CG lasts exactly 6 cycles; CY 3, AR 2, then HG.
- Hold car_x=1 permanently →
  - CG lasts exactly 16 cycles, then CY/AR;
  - HG lasts exactly 8 cycles, then HY again; the cycle repeats every 34 cycles.
- Pulse ped_req for one cycle at HG cycle 2 →
  - HY begins at cycle 8, AR at 11, PW at 13;
  - ped_ack high at cycle 13 only; walk high for cycles 13-18;
  - AR for 2 cycles, then HG.
- car_x=1 and ped_req pulse both arrive at HG cycle 0 →
  - order is HG(8), HY(3), AR(2), CG … CY(3), AR(2), PW(6), AR(2), HG;
  - a second ped_req during PW produces no further walk.
- Assert clear low mid-CY, between clock edges →
  - hwy=GREEN, cntry=RED, walk=0 immediately;
  - after release, HG lasts a full MIN_GREEN cycles with no stale pedestrian phase.
- Throughout every scenario, the bench checks that hwy != RED and cntry != RED never hold in the same cycle.
